// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the USB RX packet sequencer.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PID,
    CHECK_PID,
    STREAM,
    DONE,
    DRAIN
  } rx_pkt_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_RX   = 2'd1,
    ERR_PID  = 2'd2,
    ERR_LEN  = 2'd3
  } err_code_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  // The upper nibble of a PID byte is the ones' complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/pkt_byte_counter.sv
// Payload byte counter with synchronous clear and a full-packet flag.
module pkt_byte_counter #(
  parameter int LEN_W       = 7,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [LEN_W-1:0] count,
  output logic             at_max
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= count + LEN_W'(1);
  end

  assign at_max = (count == LEN_W'(MAX_PAYLOAD));

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Packet sequencer: pops the RX FIFO, checks the PID, streams payload over
// valid/ready and closes every packet with exactly one done or error pulse.
module rx_pkt_ctrl
  import rx_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int LEN_W       = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rcving,
  input  logic             r_error,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_r_enable,
  output logic             fifo_flush,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             pkt_start,
  output logic [3:0]       pid,
  output logic             pkt_done,
  output logic [LEN_W-1:0] byte_count,
  output logic             pkt_err,
  output logic [1:0]       err_code
);

  rx_pkt_state_t    state;
  err_code_t        err_lat;
  logic [7:0]       pid_byte;
  logic [LEN_W-1:0] count;
  logic             at_max;
  logic             pop_ok;
  logic             stream_pop;

  // A new byte may enter the output register when it is empty or being drained.
  assign pop_ok        = !fifo_empty && (!dout_valid || dout_ready);
  assign stream_pop    = (state == STREAM) && !r_error && pop_ok && !at_max;
  assign fifo_r_enable = stream_pop || ((state == WAIT_PID) && !r_error && !fifo_empty);

  pkt_byte_counter #(
    .LEN_W       (LEN_W),
    .MAX_PAYLOAD (MAX_PAYLOAD)
  ) u_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (state == CHECK_PID),
    .en     (stream_pop),
    .count  (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      err_lat    <= ERR_NONE;
      pid_byte   <= '0;
      fifo_flush <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pkt_start  <= 1'b0;
      pid        <= '0;
      pkt_done   <= 1'b0;
      byte_count <= '0;
      pkt_err    <= 1'b0;
      err_code   <= '0;
    end else begin
      pkt_start  <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      fifo_flush <= 1'b0;
      case (state)
        IDLE: if (rcving) state <= WAIT_PID;
        WAIT_PID: begin
          if (r_error) begin
            err_lat <= ERR_RX;
            state   <= DRAIN;
          end else if (!fifo_empty) begin
            pid_byte <= fifo_rdata;
            state    <= CHECK_PID;
          end else if (!rcving) begin
            err_lat <= ERR_RX;
            state   <= DRAIN;
          end
        end
        CHECK_PID: begin
          if (pid_ok(pid_byte)) begin
            pid       <= pid_byte[3:0];
            pkt_start <= 1'b1;
            state     <= STREAM;
          end else begin
            err_lat <= ERR_PID;
            state   <= DRAIN;
          end
        end
        STREAM: begin
          if (r_error) begin
            err_lat    <= ERR_RX;
            dout_valid <= 1'b0;
            state      <= DRAIN;
          end else if (pop_ok && at_max) begin
            err_lat    <= ERR_LEN;
            dout_valid <= 1'b0;
            state      <= DRAIN;
          end else if (pop_ok) begin
            dout       <= fifo_rdata;
            dout_valid <= 1'b1;
          end else begin
            if (dout_valid && dout_ready) dout_valid <= 1'b0;
            // pkt_done is registered on entry so it is high for the DONE cycle itself.
            if (!rcving && fifo_empty && (!dout_valid || dout_ready)) begin
              pkt_done   <= 1'b1;
              byte_count <= count;
              state      <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          dout_valid <= 1'b0;
          if (!rcving) begin
            fifo_flush <= 1'b1;
            pkt_err    <= 1'b1;
            err_code   <= err_lat;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Directed bench for rx_pkt_ctrl with a queue-based show-ahead FIFO model.
module tb_rx_pkt_ctrl;

  localparam int LEN_W = 7;
  localparam int MAXP  = 4;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             rcving = 1'b0;
  logic             r_error = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_rdata = 8'h00;
  logic             fifo_r_enable;
  logic             fifo_flush;
  logic [7:0]       dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             pkt_start;
  logic [3:0]       pid;
  logic             pkt_done;
  logic [LEN_W-1:0] byte_count;
  logic             pkt_err;
  logic [1:0]       err_code;

  rx_pkt_ctrl #(.MAX_PAYLOAD(MAXP), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rcving        (rcving),
    .r_error       (r_error),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_r_enable (fifo_r_enable),
    .fifo_flush    (fifo_flush),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .pkt_start     (pkt_start),
    .pid           (pid),
    .pkt_done      (pkt_done),
    .byte_count    (byte_count),
    .pkt_err       (pkt_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  logic [26:0] outs_vec;
  assign outs_vec = {fifo_r_enable, fifo_flush, dout, dout_valid, pkt_start, pid,
                     pkt_done, byte_count, pkt_err, err_code};

  int checks = 0;
  int errors = 0;

  // FIFO model
  logic [7:0] fq[$];
  logic       pop_pend = 1'b0;
  logic       flush_pend = 1'b0;

  task automatic refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh_fifo();
  endtask

  always @(posedge clk) begin
    #1;
    if (flush_pend) fq.delete();
    else if (pop_pend && fq.size() != 0) void'(fq.pop_front());
    refresh_fifo();
  end

  // Monitor
  logic [7:0] beats[$];
  int cyc = 0;
  int start_cnt, done_cnt, err_cnt, flush_cnt, flush_with_err, pop_cnt, valid_seen;
  int last_beat_cyc, done_cyc;
  logic [3:0]       pid_at_start;
  logic [LEN_W-1:0] bc_at_done;
  logic [1:0]       code_at_err;

  always @(negedge clk) begin
    pop_pend   = fifo_r_enable;
    flush_pend = fifo_flush;
    if (dout_valid && dout_ready) begin
      beats.push_back(dout);
      last_beat_cyc = cyc;
    end
    if (dout_valid)    valid_seen++;
    if (fifo_r_enable) pop_cnt++;
    if (pkt_start) begin start_cnt++; pid_at_start = pid; end
    if (pkt_done)  begin done_cnt++; bc_at_done = byte_count; done_cyc = cyc; end
    if (pkt_err)   begin err_cnt++; code_at_err = err_code; end
    if (fifo_flush) flush_cnt++;
    if (fifo_flush && pkt_err) flush_with_err++;
    cyc++;
  end

  task automatic clear_mon();
    beats.delete();
    start_cnt = 0; done_cnt = 0; err_cnt = 0; flush_cnt = 0;
    flush_with_err = 0; pop_cnt = 0; valid_seen = 0;
    last_beat_cyc = -100; done_cyc = -200;
    pid_at_start = 4'h0; bc_at_done = '0; code_at_err = 2'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_outcome(input string name, input int budget);
    int n = 0;
    while ((done_cnt + err_cnt) == 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if ((done_cnt + err_cnt) == 0) begin
      errors++;
      $display("FAIL %s timeout: no pkt_done/pkt_err within %0d cycles", name, budget);
    end
  endtask

  task automatic check_beats(input string name, input logic [7:0] exp[$]);
    logic [7:0] got;
    checks++;
    if (beats.size() != exp.size()) begin
      errors++;
      $display("FAIL %s beat count: got %0d expected %0d", name, beats.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < beats.size()) ? beats[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got %h expected %h", name, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if (outs_vec !== 27'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs_vec);
    end
    n_rst = 1'b1;
    tick(3);
    checks++;
    if (outs_vec !== 27'd0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", outs_vec);
    end
  endtask

  task automatic test_reset_mid_stream();
    clear_mon();
    push(8'hC3); push(8'h01); push(8'h02);
    dout_ready = 1'b0;
    rcving = 1'b1;
    tick(6);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h01) begin
      errors++; $display("FAIL midrst_pre: got valid=%b dout=%h expected valid=1 dout=01", dout_valid, dout);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (outs_vec !== 27'd0) begin
      errors++; $display("FAIL midrst_async: got %h expected 0", outs_vec);
    end
    fq.delete();
    refresh_fifo();
    rcving = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(3);
    checks++;
    if (done_cnt + err_cnt !== 0) begin
      errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", done_cnt + err_cnt);
    end
  endtask

  task automatic test_good_packet();
    clear_mon();
    push(8'hC3); push(8'h11); push(8'h22); push(8'h33);
    dout_ready = 1'b1;
    rcving = 1'b1;
    tick(8);
    rcving = 1'b0;
    wait_outcome("good", 20);
    tick(2);
    checks++;
    if (start_cnt !== 1 || pid_at_start !== 4'h3) begin
      errors++; $display("FAIL good_start: got cnt=%0d pid=%h expected cnt=1 pid=3", start_cnt, pid_at_start);
    end
    check_beats("good", '{8'h11, 8'h22, 8'h33});
    checks++;
    if (done_cnt !== 1 || bc_at_done !== 7'd3 || byte_count !== 7'd3) begin
      errors++; $display("FAIL good_done: got cnt=%0d bc=%0d expected cnt=1 bc=3", done_cnt, bc_at_done);
    end
    checks++;
    if (err_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL good_no_err: got err=%0d flush=%0d expected 0 0", err_cnt, flush_cnt);
    end
    checks++;
    if (pid !== 4'h3) begin
      errors++; $display("FAIL good_pid_hold: got %h expected 3", pid);
    end
  endtask

  task automatic test_bad_pid();
    clear_mon();
    push(8'hC2); push(8'hAA);
    dout_ready = 1'b1;
    rcving = 1'b1;
    tick(6);
    rcving = 1'b0;
    wait_outcome("badpid", 20);
    tick(2);
    checks++;
    if (start_cnt !== 0 || valid_seen !== 0 || done_cnt !== 0) begin
      errors++; $display("FAIL badpid_quiet: got start=%0d valid=%0d done=%0d expected 0 0 0", start_cnt, valid_seen, done_cnt);
    end
    checks++;
    if (err_cnt !== 1 || code_at_err !== 2'd2 || flush_with_err !== 1) begin
      errors++; $display("FAIL badpid_err: got err=%0d code=%0d flush_with_err=%0d expected 1 2 1", err_cnt, code_at_err, flush_with_err);
    end
    checks++;
    if (pop_cnt !== 1 || fq.size() !== 0) begin
      errors++; $display("FAIL badpid_fifo: got pops=%0d left=%0d expected 1 0", pop_cnt, fq.size());
    end
  endtask

  task automatic test_rx_error();
    clear_mon();
    push(8'hC3); push(8'h01); push(8'h02);
    dout_ready = 1'b1;
    rcving = 1'b1;
    tick(8);
    dout_ready = 1'b0;
    push(8'h03);
    tick(2);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h03) begin
      errors++; $display("FAIL rxerr_pre: got valid=%b dout=%h expected 1 03", dout_valid, dout);
    end
    r_error = 1'b1;
    tick(1);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL rxerr_valid_drop: got %b expected 0", dout_valid);
    end
    dout_ready = 1'b1;
    tick(2);
    rcving = 1'b0;
    wait_outcome("rxerr", 20);
    tick(2);
    r_error = 1'b0;
    check_beats("rxerr", '{8'h01, 8'h02});
    checks++;
    if (err_cnt !== 1 || code_at_err !== 2'd1 || done_cnt !== 0 || flush_with_err !== 1) begin
      errors++; $display("FAIL rxerr_outcome: got err=%0d code=%0d done=%0d fwe=%0d expected 1 1 0 1", err_cnt, code_at_err, done_cnt, flush_with_err);
    end
  endtask

  task automatic test_overlength();
    clear_mon();
    push(8'hC3);
    for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
    dout_ready = 1'b1;
    rcving = 1'b1;
    tick(12);
    rcving = 1'b0;
    wait_outcome("ovl", 20);
    tick(2);
    check_beats("ovl", '{8'hA1, 8'hA2, 8'hA3, 8'hA4});
    checks++;
    if (err_cnt !== 1 || code_at_err !== 2'd3 || done_cnt !== 0) begin
      errors++; $display("FAIL ovl_outcome: got err=%0d code=%0d done=%0d expected 1 3 0", err_cnt, code_at_err, done_cnt);
    end
    checks++;
    if (pop_cnt !== 5 || fq.size() !== 0 || flush_with_err !== 1) begin
      errors++; $display("FAIL ovl_fifo: got pops=%0d left=%0d fwe=%0d expected 5 0 1", pop_cnt, fq.size(), flush_with_err);
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    push(8'hC3); push(8'h55); push(8'h66); push(8'h77);
    dout_ready = 1'b0;
    rcving = 1'b1;
    tick(5);
    rcving = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h55 || fifo_r_enable !== 1'b0) begin
        errors++; $display("FAIL bp_hold %0d: got valid=%b dout=%h ren=%b expected 1 55 0", i, dout_valid, dout, fifo_r_enable);
      end
      tick(1);
    end
    dout_ready = 1'b1;
    wait_outcome("bp", 20);
    tick(2);
    check_beats("bp", '{8'h55, 8'h66, 8'h77});
    checks++;
    if (done_cnt !== 1 || bc_at_done !== 7'd3 || err_cnt !== 0) begin
      errors++; $display("FAIL bp_done: got done=%0d bc=%0d err=%0d expected 1 3 0", done_cnt, bc_at_done, err_cnt);
    end
    checks++;
    if (done_cyc !== last_beat_cyc + 1) begin
      errors++; $display("FAIL bp_done_latency: got %0d cycles expected 1", done_cyc - last_beat_cyc);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_reset_mid_stream();
    test_good_packet();
    test_bad_pid();
    test_rx_error();
    test_overlength();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rx_pkt_ctrl.md
Name: rx_pkt_ctrl

Overview:
Packet-level sequencer that sits behind the USB receiver control unit and its RX byte FIFO. It tracks the receiver's rcving/r_error status and pops bytes from the FIFO. It validates the PID byte, then streams payload bytes to a downstream consumer over a valid/ready handshake. Each packet ends with exactly one outcome pulse, either done with a byte count or error with a code, and the FIFO is flushed after errors.

Parameters:
MAX_PAYLOAD, 64, maximum data bytes after the PID. CRC bytes count as data; CRC is not checked here.
LEN_W, 7, width of byte_count; must satisfy 2^LEN_W > MAX_PAYLOAD.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rcving  in  1  receiver busy with a packet
r_error  in  1  receiver error flag
fifo_empty  in  1  RX FIFO empty
fifo_rdata  in  8  RX FIFO head byte (show-ahead, valid whenever !fifo_empty)
fifo_r_enable  out  1  pop strobe, combinational
fifo_flush  out  1  one-cycle FIFO clear
dout  out  8  payload byte, registered
dout_valid  out  1  dout holds an unconsumed byte
dout_ready  in  1  consumer accepts dout
pkt_start  out  1  one-cycle pulse when PID accepted
pid  out  4  accepted PID, registered, held until next pkt_start
pkt_done  out  1  one-cycle pulse at good end of packet
byte_count  out  LEN_W  data bytes delivered, valid with pkt_done, held afterwards
pkt_err  out  1  one-cycle pulse at end of failed packet
err_code  out  2  0 none, 1 rx error, 2 PID check fail, 3 overlength; valid with pkt_err, held until next pkt_err or reset

Behaviour:
- Clock and reset: single clock clk. n_rst is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; pid=0, byte_count=0, err_code=0. Reset mid-packet abandons the packet silently, with no pulse emitted.
- State IDLE: go to WAIT_PID when rcving=1. r_error is ignored in IDLE, because the receiver holds it in its error-idle state.
- State WAIT_PID, evaluated in priority order:
  - r_error=1: set err 1, go to DRAIN.
  - !fifo_empty: fifo_r_enable=1, latch fifo_rdata into pid_byte, go to CHECK_PID.
  - rcving=0 and fifo_empty (empty packet): set err 1, go to DRAIN.
- State CHECK_PID, 1 cycle:
  - pid_byte[7:4] == ~pid_byte[3:0]: pid<=pid_byte[3:0], pkt_start=1, clear counter, go to STREAM.
  - Otherwise: set err 2, go to DRAIN.
- State STREAM, evaluated in priority order:
  - r_error=1: set err 1, clear dout_valid, go to DRAIN. No pop in this cycle.
  - A pop is allowed when !fifo_empty and (!dout_valid or dout_ready).
  - Pop allowed and count==MAX_PAYLOAD: set err 3, clear dout_valid, go to DRAIN, no pop.
  - Pop allowed otherwise: fifo_r_enable=1, dout<=fifo_rdata, dout_valid<=1, count+1.
  - dout_valid and dout_ready with no pop: dout_valid<=0.
  - rcving=0, fifo_empty and dout_valid handshake completing or already 0: go to DONE.
- State DONE: pkt_done=1, byte_count<=count, go to IDLE. Latency: pkt_done comes 1 cycle after the last byte is accepted.
- State DRAIN: dout_valid=0, fifo_r_enable=0. Wait for rcving=0, then fifo_flush=1 and pkt_err=1 in the same cycle with the latched code, and go to IDLE.
- Handshake rules:
  - dout is stable while dout_valid=1 and dout_ready=0.
  - Byte order is preserved.
  - Throughput is one byte per cycle under continuous ready.
- Pulse exclusivity: pkt_done and pkt_err are never both asserted for one packet; exactly one of them follows each IDLE exit.

Decomposition:
- Package rx_pkt_pkg:
  - rx_pkt_state enum: IDLE, WAIT_PID, CHECK_PID, STREAM, DONE, DRAIN.
  - err_code enum: ERR_NONE, ERR_RX, ERR_PID, ERR_LEN.
  - PID constants: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, DATA1=4'b1011, ACK=4'b0010.
- One sub-module, pkt_byte_counter (parameter LEN_W): synchronous clear, enable, count output, at_max compare against MAX_PAYLOAD.

Test Plan:
- Assert n_rst low during STREAM with dout_valid=1 -> all outputs 0 asynchronously; next rcving restarts cleanly with no pulse for the aborted packet.
- Good packet: FIFO holds C3,11,22,33, dout_ready=1, then rcving falls -> pkt_start with pid=3, dout beats 11,22,33, pkt_done with byte_count=3, no pkt_err.
- Bad PID: FIFO holds C2,AA -> no pkt_start, no dout_valid; when rcving falls, fifo_flush and pkt_err pulse together with err_code=2.
- r_error mid-packet: C3,01,02 delivered, then r_error=1 -> dout_valid drops the same cycle; after rcving falls, pkt_err with err_code=1; no pkt_done.
- Overlength with MAX_PAYLOAD=4: C3 followed by 5 data bytes -> exactly 4 dout beats, then pkt_err with err_code=3; 5th byte not popped, removed by fifo_flush.
- Backpressure: hold dout_ready=0 for 5 cycles with 3 bytes queued -> dout stable, fifo_r_enable=0; on release, bytes arrive in order and pkt_done reports byte_count=3.
